inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 136 +++++++++++++
 tb/tb_inst_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: byte-addressed PC, one-cycle fetch into an IF/ID register, branch redirect and stall.
// Define FETCH_BOUND_CHECK_EN to enable fetch-fault detection (misaligned or beyond-depth PC) and the HALT state.
`timescale 1ns/1ps

module inst_fetch #(
    parameter int unsigned       width    = 32,
    parameter int unsigned       adr_in   = 64,
    parameter int unsigned       depth    = 80,
    parameter logic [adr_in-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [adr_in-1:0] branch_target,
    output logic [adr_in-1:0] read_adr,
    input  logic [width-1:0]  instruction,
    output logic [adr_in-1:0] if_pc,
    output logic [width-1:0]  if_inst,
    output logic              if_valid,
    output logic              fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [width-1:0]  NOP     = width'(32'h0000_0013);
    localparam logic [adr_in-1:0] PC_STEP = adr_in'(4);
    localparam logic [adr_in-1:0] DEPTH_W = adr_in'(depth);

    logic [1:0]        r_state;
    logic [adr_in-1:0] r_pc;
    logic [adr_in-1:0] r_if_pc;
    logic [width-1:0]  r_if_inst;
    logic              r_if_valid;
    logic              r_fault;

    logic [1:0]        w_state_nxt;
    logic [adr_in-1:0] w_pc_nxt;
    logic [adr_in-1:0] w_if_pc_nxt;
    logic [width-1:0]  w_if_inst_nxt;
    logic              w_if_valid_nxt;
    logic              w_fault_nxt;
    logic [adr_in-1:0] w_word_adr;
    logic              w_fetch_fault;

    assign w_word_adr = r_pc >> 2;

`ifdef FETCH_BOUND_CHECK_EN
    assign w_fetch_fault = (r_pc[1:0] != 2'b00) || (w_word_adr >= DEPTH_W);
`else
    // Range compare kept only so the depth parameter stays referenced; it drives nothing.
    logic w_unused_range;
    assign w_unused_range = (w_word_adr >= DEPTH_W);
    assign w_fetch_fault  = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-value gets a hold default first so no path can infer a latch.
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_pc_nxt    = r_if_pc;
        w_if_inst_nxt  = r_if_inst;
        w_if_valid_nxt = r_if_valid;
        w_fault_nxt    = r_fault;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_RUN;
                if (branch_taken) begin
                    w_pc_nxt       = branch_target;
                    w_if_inst_nxt  = NOP;
                    w_if_valid_nxt = 1'b0;
                end
            end

            S_RUN: begin
                // Redirect beats a fault on the old PC, and a fault beats stall.
                if (branch_taken) begin
                    w_pc_nxt       = branch_target;
                    w_if_inst_nxt  = NOP;
                    w_if_valid_nxt = 1'b0;
                end else if (w_fetch_fault) begin
                    w_fault_nxt    = 1'b1;
                    w_if_inst_nxt  = NOP;
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = S_HALT;
                end else if (!stall) begin
                    w_if_inst_nxt  = instruction;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + PC_STEP;
                end
            end

            S_HALT: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_fault_nxt = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_if_pc    <= '0;
            r_if_inst  <= NOP;
            r_if_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_inst  <= w_if_inst_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign read_adr = w_word_adr;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;
    assign if_valid = r_if_valid;
    assign fault    = r_fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal expectations, then random stall/branch/reset
// traffic checked every cycle against a behavioural fetch model. Honours FETCH_BOUND_CHECK_EN like the design.
`timescale 1ns/1ps

module tb_inst_fetch;

    localparam int          W     = 32;
    localparam int          ADR   = 64;
    localparam int          DEPTH = 80;
    localparam logic [63:0] NOP   = 64'h13;
`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           stall;
    logic           branch_taken;
    logic [ADR-1:0] branch_target;
    logic [ADR-1:0] read_adr;
    logic [W-1:0]   instruction;
    logic [ADR-1:0] if_pc;
    logic [W-1:0]   if_inst;
    logic           if_valid;
    logic           fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [DEPTH];

    inst_fetch #(.width(W), .adr_in(ADR), .depth(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .read_adr(read_adr), .instruction(instruction),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words beyond the memory return an address-tagged pattern so stray fetches are recognisable.
    function automatic logic [31:0] mem_word(input logic [63:0] word);
        if (word < 64'(DEPTH)) return mem[int'(word)];
        return 32'hF000_0000 | {4'h0, word[27:0]};
    endfunction

    always_comb instruction = mem_word(read_adr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of operation plus the architecturally visible values.
    typedef enum {M_FIRST, M_FETCHING, M_HALTED} mode_t;
    mode_t       m_mode;
    bit          m_known = 1'b0;
    logic [63:0] m_pc;
    logic [63:0] m_if_pc;
    logic [63:0] m_if_inst;
    bit          m_if_valid;
    bit          m_fault;

    function automatic bit bad_fetch(input logic [63:0] pc);
        return BOUND && ((pc % 4 != 0) || (pc / 4 >= 64'(DEPTH)));
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_known    = 1'b1;
            m_mode     = M_FIRST;
            m_pc       = 64'd0;
            m_if_pc    = 64'd0;
            m_if_inst  = NOP;
            m_if_valid = 1'b0;
            m_fault    = 1'b0;
        end else if (m_known) begin
            if (branch_taken && m_mode == M_HALTED) begin
                m_pc    = branch_target;
                m_fault = 1'b0;
                m_mode  = M_FETCHING;
            end else if (branch_taken) begin
                m_pc       = branch_target;
                m_if_inst  = NOP;
                m_if_valid = 1'b0;
                m_mode     = M_FETCHING;
            end else if (m_mode == M_FIRST) begin
                m_mode = M_FETCHING;
            end else if (m_mode == M_FETCHING && bad_fetch(m_pc)) begin
                m_fault    = 1'b1;
                m_if_inst  = NOP;
                m_if_valid = 1'b0;
                m_mode     = M_HALTED;
            end else if (m_mode == M_FETCHING && !stall) begin
                m_if_inst  = 64'(mem_word(m_pc / 4));
                m_if_pc    = m_pc;
                m_if_valid = 1'b1;
                m_pc       = m_pc + 64'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("model read_adr", 64'(read_adr), m_pc >> 2);
            check("model if_valid", 64'(if_valid), 64'(m_if_valid));
            check("model fault",    64'(fault),    64'(m_fault));
            check("model if_pc",    64'(if_pc),    m_if_pc);
            check("model if_inst",  64'(if_inst),  m_if_inst);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit b, input logic [63:0] t);
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = (i < 10) ? 32'(i) : $urandom;
        drive(1'b0, 1'b0, 1'b0, 64'd0);

        // Reset state
        tick();
        tick();
        check("rst read_adr", 64'(read_adr), 64'd0);
        check("rst if_valid", 64'(if_valid), 64'd0);
        check("rst if_inst",  64'(if_inst),  NOP);
        check("rst if_pc",    64'(if_pc),    64'd0);
        check("rst fault",    64'(fault),    64'd0);

        // Sequential fetch of words 0..9 after the IDLE cycle
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        check("idle if_valid", 64'(if_valid), 64'd0);
        check("idle read_adr", 64'(read_adr), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("seq if_inst",  64'(if_inst),  64'(i));
            check("seq if_pc",    64'(if_pc),    64'(4 * i));
            check("seq if_valid", 64'(if_valid), 64'd1);
        end

        // Stall at pc=0x8
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall if_inst",  64'(if_inst),  64'd1);
            check("stall if_pc",    64'(if_pc),    64'h4);
            check("stall read_adr", 64'(read_adr), 64'd2);
        end
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        check("resume if_inst", 64'(if_inst), 64'd2);
        check("resume if_pc",   64'(if_pc),   64'h8);

        // Branch wins over stall
        drive(1'b1, 1'b1, 1'b1, 64'h10);
        tick();
        check("branch if_valid", 64'(if_valid), 64'd0);
        check("branch if_inst",  64'(if_inst),  NOP);
        check("branch if_pc",    64'(if_pc),    64'h8);
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        check("target if_inst", 64'(if_inst), 64'd4);
        check("target if_pc",   64'(if_pc),   64'h10);

        // Branch to word 80, one past the memory
        drive(1'b1, 1'b0, 1'b1, 64'h140);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        check("oob read_adr", 64'(read_adr), 64'd80);
        tick();
`ifdef FETCH_BOUND_CHECK_EN
        check("oob fault",    64'(fault),    64'd1);
        check("oob if_valid", 64'(if_valid), 64'd0);
        check("oob pc held",  64'(read_adr), 64'd80);
        tick();
        check("halt pc held", 64'(read_adr), 64'd80);
        check("halt fault",   64'(fault),    64'd1);
        drive(1'b1, 1'b0, 1'b1, 64'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        check("recover fault",    64'(fault),    64'd0);
        check("recover read_adr", 64'(read_adr), 64'd0);
        tick();
        check("recover if_inst",  64'(if_inst),  64'd0);
        check("recover if_valid", 64'(if_valid), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 64'h6);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        check("misalign fault", 64'(fault), 64'd1);
        // Reset out of HALT
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        check("halt-rst read_adr", 64'(read_adr), 64'd0);
        check("halt-rst fault",    64'(fault),    64'd0);
        tick();
        check("halt-rst idle valid", 64'(if_valid), 64'd0);
        check("halt-rst idle pc",    64'(read_adr), 64'd0);
        tick();
        check("halt-rst fetch", 64'(if_inst), 64'd0);
`else
        check("oob no fault", 64'(fault),    64'd0);
        check("oob if_valid", 64'(if_valid), 64'd1);
        check("oob if_pc",    64'(if_pc),    64'h140);
        check("oob if_inst",  64'(if_inst),  64'hF000_0050);
        check("oob next adr", 64'(read_adr), 64'd81);
        // PC wraps at the top of the address space
        drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        check("wrap read_adr", 64'(read_adr), 64'd0);
        check("wrap if_pc",    64'(if_pc),    64'hFFFF_FFFF_FFFF_FFFC);
`endif

        // Random traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [63:0] tgt;
            case ($urandom_range(0, 5))
                0: tgt = 64'($urandom_range(0, DEPTH - 1)) * 64'd4;
                1: tgt = 64'(DEPTH * 4 - 4);
                2: tgt = 64'(DEPTH * 4);
                3: tgt = 64'($urandom_range(0, 63));
                4: tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                default: tgt = {$urandom, $urandom};
            endcase
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, tgt);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
